usb_tx_sequencer: RTL and testbench

Transmit-side packet controller between the SIE endpoint logic and the transceiver's TX port (sie modport: tx_data/tx_valid/tx_ready). It arbitrates between handshake requests (ACK/NAK/STALL) and data-packet requests (DATA0/DATA1). It builds each packet as PID byte, then payload bytes read from the endpoint TX FIFO, then CRC16 (data packets only). It drives the byte handshake, aborts on USB reset, and flags FIFO underrun.

---
 rtl/usb_pkg.sv | 35 +++
 rtl/usb_tx_sequencer_if.sv | 9 +
 rtl/usb_crc16.sv | 20 ++
 rtl/usb_tx_sequencer.sv | 167 ++++++++++++++++
 tb/tb_usb_tx_sequencer.sv | 450 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/usb_pkg.sv
// Shared USB definitions: PID encodings, CRC16 constants, PID byte helper and
// the transmit sequencer state type.
package usb_pkg;

  typedef enum logic [3:0] {
    PID_OUT   = 4'b0001,
    PID_IN    = 4'b1001,
    PID_SOF   = 4'b0101,
    PID_SETUP = 4'b1101,
    PID_DATA0 = 4'b0011,
    PID_DATA1 = 4'b1011,
    PID_ACK   = 4'b0010,
    PID_NAK   = 4'b1010,
    PID_STALL = 4'b1110
  } pid_t;

  localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
  localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;

  // On the wire a PID byte carries its own ones-complement check nibble.
  function automatic logic [7:0] pid_byte(input logic [3:0] pid);
    return {~pid, pid};
  endfunction

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREF,
    ST_PID,
    ST_DATA,
    ST_CRC_LO,
    ST_CRC_HI,
    ST_GAP
  } tx_state_t;

endpackage

// File: rtl/usb_tx_sequencer_if.sv
// Byte handshake between the packet sequencer and the transceiver TX port.
interface usb_tx_sequencer_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/usb_crc16.sv
// Byte-wide next-state function of the USB CRC16 (reflected 0x8005), LSB first.
// Purely combinational so the RX checker can share it.
module usb_crc16
  import usb_pkg::*;
(
  input  logic [15:0] crc_in,
  input  logic [7:0]  data_in,
  output logic [15:0] crc_out
);

  // NOTE: blocking assignments are intentional here; each loop pass builds on
  // the previous one within the same combinational evaluation.
  always_comb begin
    crc_out = crc_in ^ {8'h00, data_in};
    for (int i = 0; i < 8; i++) begin
      crc_out = crc_out[0] ? ((crc_out >> 1) ^ CRC16_POLY_REFL) : (crc_out >> 1);
    end
  end

endmodule

// File: rtl/usb_tx_sequencer.sv
// Transmit packet controller: arbitrates handshake vs data requests and emits
// PID, FIFO payload and inverted CRC16 over a byte valid/ready handshake.
module usb_tx_sequencer
  import usb_pkg::*;
#(
  parameter int MAX_LEN = 64,
  parameter int LEN_W   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   usb_reset,
  input  logic                   hs_req,
  input  logic [3:0]             hs_pid,
  input  logic                   dat_req,
  input  logic [3:0]             dat_pid,
  input  logic [LEN_W-1:0]       dat_len,
  input  logic [7:0]             fifo_q,
  input  logic                   fifo_rdempty,
  output logic                   fifo_rdreq,
  usb_tx_sequencer_if.master     tx,
  output logic                   hs_ack,
  output logic                   dat_ack,
  output logic                   done,
  output logic                   underrun,
  output logic                   busy
);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  tx_state_t        state;
  logic [LEN_W-1:0] rem;
  logic [15:0]      crc;
  logic [15:0]      crc_next;
  logic [7:0]       nxt;
  logic [7:0]       cur_byte;
  logic [LEN_W-1:0] len_eff;
  logic             is_hs;
  logic             cap_pend;

  // A prefetched byte shows up on fifo_q one cycle after the read strobe; it is
  // usable directly in that cycle and parked in nxt afterwards.
  assign cur_byte = cap_pend ? fifo_q : nxt;
  assign len_eff  = (dat_len > LEN_MAX) ? LEN_MAX : dat_len;
  assign busy     = (state != ST_IDLE);

  usb_crc16 u_crc16 (
    .crc_in  (crc),
    .data_in (cur_byte),
    .crc_out (crc_next)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      tx.tx_data  <= 8'h00;
      tx.tx_valid <= 1'b0;
      fifo_rdreq  <= 1'b0;
      hs_ack      <= 1'b0;
      dat_ack     <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      rem         <= '0;
      crc         <= CRC16_INIT;
      nxt         <= 8'h00;
      is_hs       <= 1'b0;
      cap_pend    <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so each one is exactly one clock
      // wide; branches below only ever raise them.
      hs_ack     <= 1'b0;
      dat_ack    <= 1'b0;
      done       <= 1'b0;
      underrun   <= 1'b0;
      fifo_rdreq <= 1'b0;
      cap_pend   <= fifo_rdreq;
      if (cap_pend) nxt <= fifo_q;

      if (usb_reset) begin
        state       <= ST_IDLE;
        tx.tx_valid <= 1'b0;
        cap_pend    <= 1'b0;
      end else begin
        unique case (state)
          ST_IDLE: begin
            if (hs_req) begin
              hs_ack      <= 1'b1;
              is_hs       <= 1'b1;
              tx.tx_data  <= pid_byte(hs_pid);
              tx.tx_valid <= 1'b1;
              state       <= ST_PID;
            end else if (dat_req) begin
              dat_ack    <= 1'b1;
              is_hs      <= 1'b0;
              tx.tx_data <= pid_byte(dat_pid);
              rem        <= len_eff;
              crc        <= CRC16_INIT;
              if (len_eff == '0) begin
                tx.tx_valid <= 1'b1;
                state       <= ST_PID;
              end else if (fifo_rdempty) begin
                underrun <= 1'b1;
                state    <= ST_GAP;
              end else begin
                fifo_rdreq <= 1'b1;
                state      <= ST_PREF;
              end
            end
          end

          ST_PREF: begin
            tx.tx_valid <= 1'b1;
            state       <= ST_PID;
          end

          ST_PID, ST_DATA: begin
            if (tx.tx_ready) begin
              if (is_hs) begin
                done        <= 1'b1;
                tx.tx_valid <= 1'b0;
                state       <= ST_GAP;
              end else if (rem != '0) begin
                tx.tx_data <= cur_byte;
                crc        <= crc_next;
                rem        <= rem - LEN_ONE;
                state      <= ST_DATA;
                // Prefetch the following byte while this one is on the wire.
                if (rem != LEN_ONE) begin
                  if (fifo_rdempty) begin
                    underrun    <= 1'b1;
                    tx.tx_valid <= 1'b0;
                    state       <= ST_GAP;
                  end else begin
                    fifo_rdreq <= 1'b1;
                  end
                end
              end else begin
                tx.tx_data <= ~crc[7:0];
                state      <= ST_CRC_LO;
              end
            end
          end

          ST_CRC_LO: begin
            if (tx.tx_ready) begin
              tx.tx_data <= ~crc[15:8];
              state      <= ST_CRC_HI;
            end
          end

          ST_CRC_HI: begin
            if (tx.tx_ready) begin
              done        <= 1'b1;
              tx.tx_valid <= 1'b0;
              state       <= ST_GAP;
            end
          end

          ST_GAP: state <= ST_IDLE;

          default: state <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer with a FIFO model, a transceiver model
// that accepts a byte every few cycles, and an event monitor.
module tb_usb_tx_sequencer;
  import usb_pkg::*;

  localparam int MAX_LEN = 64;
  localparam int LEN_W   = 7;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             usb_reset = 1'b0;
  logic             hs_req = 1'b0;
  logic [3:0]       hs_pid = 4'h0;
  logic             dat_req = 1'b0;
  logic [3:0]       dat_pid = 4'h0;
  logic [LEN_W-1:0] dat_len = '0;
  logic [7:0]       fifo_q = 8'h00;
  logic             fifo_rdempty;
  logic             fifo_rdreq;
  logic             hs_ack, dat_ack, done, underrun, busy;

  usb_tx_sequencer_if tx_if ();

  usb_tx_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .usb_reset    (usb_reset),
    .hs_req       (hs_req),
    .hs_pid       (hs_pid),
    .dat_req      (dat_req),
    .dat_pid      (dat_pid),
    .dat_len      (dat_len),
    .fifo_q       (fifo_q),
    .fifo_rdempty (fifo_rdempty),
    .fifo_rdreq   (fifo_rdreq),
    .tx           (tx_if),
    .hs_ack       (hs_ack),
    .dat_ack      (dat_ack),
    .done         (done),
    .underrun     (underrun),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Non-showahead FIFO: test writes via wr_ptr, the model owns rd_ptr.
  logic [7:0] fifo_mem [256];
  int         wr_ptr = 0;
  int         rd_ptr = 0;
  logic       flush = 1'b0;
  assign fifo_rdempty = (rd_ptr == wr_ptr);

  always @(posedge clk) begin
    if (flush) rd_ptr <= wr_ptr;
    else if (fifo_rdreq && (rd_ptr != wr_ptr)) begin
      fifo_q <= fifo_mem[rd_ptr % 256];
      rd_ptr <= rd_ptr + 1;
    end
  end

  // Transceiver: pulses tx_ready every fifth cycle while tx_valid is high.
  logic [7:0] rx_q [$];
  int         xc_cnt = 0;
  always @(negedge clk) begin
    if (!tx_if.tx_valid || tx_if.tx_ready === 1'b1) begin
      tx_if.tx_ready = 1'b0;
      xc_cnt = 0;
    end else if (xc_cnt == 3) begin
      tx_if.tx_ready = 1'b1;
      rx_q.push_back(tx_if.tx_data);
      xc_cnt = 0;
    end else begin
      xc_cnt++;
    end
  end

  // Event monitor.
  int         cyc = 0, rdreq_cnt = 0, done_cnt = 0, underrun_cnt = 0;
  int         hs_ack_cyc = 0, dat_ack_cyc = 0, pulse_wide = 0;
  logic       valid_at_done = 1'b0, busy_at_done = 1'b0, valid_at_underrun = 1'b0;
  logic [3:0] prev_pulses = 4'h0;
  always @(negedge clk) begin
    cyc++;
    if (fifo_rdreq) rdreq_cnt++;
    if (hs_ack) hs_ack_cyc = cyc;
    if (dat_ack) dat_ack_cyc = cyc;
    if (done) begin
      done_cnt++;
      valid_at_done = tx_if.tx_valid;
      busy_at_done  = busy;
    end
    if (underrun) begin
      underrun_cnt++;
      valid_at_underrun = tx_if.tx_valid;
    end
    if (({hs_ack, dat_ack, done, underrun} & prev_pulses) != 4'h0) pulse_wide++;
    prev_pulses = {hs_ack, dat_ack, done, underrun};
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] crc_bitwise(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 16'hA001;
      else             r = r >> 1;
    end
    return r;
  endfunction

  task automatic do_flush();
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic load_fifo(input logic [7:0] first, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_mem[wr_ptr % 256] = first + 8'(i);
      wr_ptr = wr_ptr + 1;
    end
  endtask

  task automatic run_until(input int n_done, input int n_under, input int max_cyc,
                           output bit timed_out);
    timed_out = 1'b1;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (dat_ack) dat_req = 1'b0;
      if (done_cnt >= n_done && underrun_cnt >= n_under) begin
        timed_out = 1'b0;
        break;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({tx_if.tx_valid, tx_if.tx_data, fifo_rdreq, hs_ack, dat_ack, done, underrun, busy} !== 14'h0) begin
      fails++;
      $display("FAIL reset_values: got %b expected all zero",
               {tx_if.tx_valid, tx_if.tx_data, fifo_rdreq, hs_ack, dat_ack, done, underrun, busy});
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_handshake();
    int rx0 = rx_q.size();
    int d0  = done_cnt;
    bit to;
    @(negedge clk); hs_req = 1'b1; hs_pid = PID_ACK;
    @(posedge clk); #1;
    tests++;
    if (hs_ack !== 1'b1 || tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hD2) begin
      fails++;
      $display("FAIL hs_first: ack=%b valid=%b data=%h expected 1 1 d2", hs_ack, tx_if.tx_valid, tx_if.tx_data);
    end
    hs_req = 1'b0;
    run_until(d0 + 1, underrun_cnt, 200, to);
    tests++;
    if (to) begin fails++; $display("FAIL hs_timeout: no done within bound"); end
    tests++;
    if (rx_q.size() - rx0 !== 1 || rx_q[rx0] !== 8'hD2) begin
      fails++;
      $display("FAIL hs_bytes: got %0d bytes first=%h expected 1 byte d2", rx_q.size() - rx0, rx_q[rx0]);
    end
    tests++;
    if (valid_at_done !== 1'b0 || busy_at_done !== 1'b1) begin
      fails++;
      $display("FAIL hs_gap: valid=%b busy=%b at done expected 0 1", valid_at_done, busy_at_done);
    end
    @(negedge clk);
    tests++;
    if (busy !== 1'b0) begin fails++; $display("FAIL hs_idle: busy=%b expected 0", busy); end
  endtask

  task automatic test_data_len0();
    logic [7:0] exp [3] = '{8'hC3, 8'h00, 8'h00};
    int rx0 = rx_q.size();
    int rd0 = rdreq_cnt;
    int d0  = done_cnt;
    bit to;
    @(negedge clk); dat_req = 1'b1; dat_pid = PID_DATA0; dat_len = '0;
    @(posedge clk); #1;
    tests++;
    if (dat_ack !== 1'b1 || tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'hC3) begin
      fails++;
      $display("FAIL len0_first: ack=%b valid=%b data=%h expected 1 1 c3", dat_ack, tx_if.tx_valid, tx_if.tx_data);
    end
    dat_req = 1'b0;
    run_until(d0 + 1, underrun_cnt, 300, to);
    tests++;
    if (to) begin fails++; $display("FAIL len0_timeout: no done within bound"); end
    tests++;
    if (rx_q.size() - rx0 !== 3) begin
      fails++; $display("FAIL len0_count: got %0d bytes expected 3", rx_q.size() - rx0);
    end
    for (int i = 0; i < 3 && rx0 + i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[rx0 + i] !== exp[i]) begin
        fails++; $display("FAIL len0_byte%0d: got %h expected %h", i, rx_q[rx0 + i], exp[i]);
      end
    end
    tests++;
    if (rdreq_cnt !== rd0) begin
      fails++; $display("FAIL len0_rdreq: got %0d reads expected 0", rdreq_cnt - rd0);
    end
  endtask

  task automatic test_data_len4();
    logic [7:0]  exp [7];
    logic [15:0] c = 16'hFFFF;
    int rx0, rd0, d0;
    bit to;
    do_flush();
    load_fifo(8'h00, 4);
    for (int i = 0; i < 4; i++) c = crc_bitwise(c, 8'(i));
    exp = '{8'h4B, 8'h00, 8'h01, 8'h02, 8'h03, ~c[7:0], ~c[15:8]};
    rx0 = rx_q.size(); rd0 = rdreq_cnt; d0 = done_cnt;
    @(negedge clk); dat_req = 1'b1; dat_pid = PID_DATA1; dat_len = 7'd4;
    @(posedge clk); #1;
    tests++;
    if (dat_ack !== 1'b1 || tx_if.tx_valid !== 1'b0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL len4_pref: ack=%b valid=%b busy=%b expected 1 0 1", dat_ack, tx_if.tx_valid, busy);
    end
    dat_req = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (tx_if.tx_valid !== 1'b1 || tx_if.tx_data !== 8'h4B) begin
      fails++;
      $display("FAIL len4_pid: valid=%b data=%h expected 1 4b", tx_if.tx_valid, tx_if.tx_data);
    end
    run_until(d0 + 1, underrun_cnt, 400, to);
    tests++;
    if (to) begin fails++; $display("FAIL len4_timeout: no done within bound"); end
    tests++;
    if (rx_q.size() - rx0 !== 7) begin
      fails++; $display("FAIL len4_count: got %0d bytes expected 7", rx_q.size() - rx0);
    end
    for (int i = 0; i < 7 && rx0 + i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[rx0 + i] !== exp[i]) begin
        fails++; $display("FAIL len4_byte%0d: got %h expected %h", i, rx_q[rx0 + i], exp[i]);
      end
    end
    tests++;
    if (rdreq_cnt - rd0 !== 4) begin
      fails++; $display("FAIL len4_rdreq: got %0d reads expected 4", rdreq_cnt - rd0);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  exp [6];
    logic [15:0] c = 16'hFFFF;
    int rx0, rd0, d0;
    bit to;
    do_flush();
    load_fifo(8'hAA, 1);
    load_fifo(8'h55, 1);
    c = crc_bitwise(c, 8'hAA);
    c = crc_bitwise(c, 8'h55);
    exp = '{8'h5A, 8'hC3, 8'hAA, 8'h55, ~c[7:0], ~c[15:8]};
    rx0 = rx_q.size(); rd0 = rdreq_cnt; d0 = done_cnt;
    @(negedge clk);
    hs_req = 1'b1; hs_pid = PID_NAK;
    dat_req = 1'b1; dat_pid = PID_DATA0; dat_len = 7'd2;
    @(posedge clk); #1;
    tests++;
    if (hs_ack !== 1'b1 || dat_ack !== 1'b0 || tx_if.tx_data !== 8'h5A) begin
      fails++;
      $display("FAIL b2b_arb: hs_ack=%b dat_ack=%b data=%h expected 1 0 5a", hs_ack, dat_ack, tx_if.tx_data);
    end
    hs_req = 1'b0;
    run_until(d0 + 2, underrun_cnt, 600, to);
    dat_req = 1'b0;
    tests++;
    if (to) begin fails++; $display("FAIL b2b_timeout: two dones not seen within bound"); end
    tests++;
    if (!(hs_ack_cyc < dat_ack_cyc)) begin
      fails++; $display("FAIL b2b_order: hs_ack cycle %0d dat_ack cycle %0d expected hs first", hs_ack_cyc, dat_ack_cyc);
    end
    tests++;
    if (rx_q.size() - rx0 !== 6) begin
      fails++; $display("FAIL b2b_count: got %0d bytes expected 6", rx_q.size() - rx0);
    end
    for (int i = 0; i < 6 && rx0 + i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[rx0 + i] !== exp[i]) begin
        fails++; $display("FAIL b2b_byte%0d: got %h expected %h", i, rx_q[rx0 + i], exp[i]);
      end
    end
    tests++;
    if (rdreq_cnt - rd0 !== 2) begin
      fails++; $display("FAIL b2b_rdreq: got %0d reads expected 2", rdreq_cnt - rd0);
    end
  endtask

  task automatic test_underrun();
    logic [7:0] exp [3] = '{8'hC3, 8'h10, 8'h11};
    int rx0, rd0, d0, u0;
    bit to;
    do_flush();
    load_fifo(8'h10, 3);
    rx0 = rx_q.size(); rd0 = rdreq_cnt; d0 = done_cnt; u0 = underrun_cnt;
    @(negedge clk); dat_req = 1'b1; dat_pid = PID_DATA0; dat_len = 7'd8;
    @(posedge clk); #1;
    dat_req = 1'b0;
    run_until(d0, u0 + 1, 400, to);
    repeat (20) @(negedge clk);
    tests++;
    if (to) begin fails++; $display("FAIL und_timeout: no underrun within bound"); end
    tests++;
    if (underrun_cnt - u0 !== 1 || valid_at_underrun !== 1'b0) begin
      fails++;
      $display("FAIL und_pulse: pulses=%0d valid=%b expected 1 0", underrun_cnt - u0, valid_at_underrun);
    end
    tests++;
    if (done_cnt !== d0) begin fails++; $display("FAIL und_done: got %0d dones expected 0", done_cnt - d0); end
    tests++;
    if (rx_q.size() - rx0 !== 3) begin
      fails++; $display("FAIL und_count: got %0d bytes expected 3", rx_q.size() - rx0);
    end
    for (int i = 0; i < 3 && rx0 + i < rx_q.size(); i++) begin
      tests++;
      if (rx_q[rx0 + i] !== exp[i]) begin
        fails++; $display("FAIL und_byte%0d: got %h expected %h", i, rx_q[rx0 + i], exp[i]);
      end
    end
    tests++;
    if (rdreq_cnt - rd0 !== 3 || busy !== 1'b0) begin
      fails++; $display("FAIL und_end: reads=%0d busy=%b expected 3 0", rdreq_cnt - rd0, busy);
    end
  endtask

  task automatic test_usb_reset();
    int rx0, d0, rd_snap;
    bit to;
    do_flush();
    load_fifo(8'h00, 64);
    rx0 = rx_q.size(); d0 = done_cnt;
    @(negedge clk); dat_req = 1'b1; dat_pid = PID_DATA1; dat_len = 7'd64;
    @(posedge clk); #1;
    dat_req = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rx_q.size() - rx0 >= 5) begin to = 1'b0; break; end
    end
    tests++;
    if (to) begin fails++; $display("FAIL urst_progress: packet did not reach DATA"); end
    usb_reset = 1'b1;
    hs_req = 1'b1; hs_pid = PID_ACK;
    @(posedge clk); #1;
    tests++;
    if (tx_if.tx_valid !== 1'b0 || busy !== 1'b0 || hs_ack !== 1'b0) begin
      fails++;
      $display("FAIL urst_abort: valid=%b busy=%b hs_ack=%b expected 0 0 0", tx_if.tx_valid, busy, hs_ack);
    end
    @(negedge clk);
    usb_reset = 1'b0;
    hs_req = 1'b0;
    rd_snap = rdreq_cnt;
    repeat (20) @(negedge clk);
    tests++;
    if (rdreq_cnt !== rd_snap || done_cnt !== d0) begin
      fails++;
      $display("FAIL urst_quiet: extra reads=%0d dones=%0d expected 0 0", rdreq_cnt - rd_snap, done_cnt - d0);
    end
    do_flush();
    rx0 = rx_q.size();
    @(negedge clk); hs_req = 1'b1; hs_pid = PID_ACK;
    @(posedge clk); #1;
    hs_req = 1'b0;
    run_until(d0 + 1, underrun_cnt, 200, to);
    tests++;
    if (to || rx_q.size() - rx0 !== 1 || rx_q[rx0] !== 8'hD2) begin
      fails++;
      $display("FAIL urst_recover: timeout=%b bytes=%0d first=%h expected 0 1 d2", to, rx_q.size() - rx0, rx_q[rx0]);
    end
  endtask

  task automatic test_async_reset();
    int rx0, d0;
    bit to;
    do_flush();
    load_fifo(8'hF0, 4);
    rx0 = rx_q.size();
    @(negedge clk); dat_req = 1'b1; dat_pid = PID_DATA0; dat_len = 7'd4;
    @(posedge clk); #1;
    dat_req = 1'b0;
    to = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (rx_q.size() - rx0 >= 2) begin to = 1'b0; break; end
    end
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if (to || {tx_if.tx_valid, tx_if.tx_data, fifo_rdreq, hs_ack, dat_ack, done, underrun, busy} !== 14'h0) begin
      fails++;
      $display("FAIL arst_values: timeout=%b got %b expected all zero", to,
               {tx_if.tx_valid, tx_if.tx_data, fifo_rdreq, hs_ack, dat_ack, done, underrun, busy});
    end
    @(negedge clk); rst_n = 1'b1;
    do_flush();
    rx0 = rx_q.size(); d0 = done_cnt;
    @(negedge clk); hs_req = 1'b1; hs_pid = PID_STALL;
    @(posedge clk); #1;
    hs_req = 1'b0;
    run_until(d0 + 1, underrun_cnt, 200, to);
    tests++;
    if (to || rx_q.size() - rx0 !== 1 || rx_q[rx0] !== 8'h1E) begin
      fails++;
      $display("FAIL arst_recover: timeout=%b bytes=%0d first=%h expected 0 1 1e", to, rx_q.size() - rx0, rx_q[rx0]);
    end
  endtask

  task automatic test_pulse_width();
    tests++;
    if (pulse_wide !== 0) begin
      fails++; $display("FAIL pulse_width: %0d multi-cycle pulses expected 0", pulse_wide);
    end
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_data_len0();
    test_data_len4();
    test_back_to_back();
    test_underrun();
    test_usb_reset();
    test_async_reset();
    repeat (5) @(negedge clk);
    test_pulse_width();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
